mem_controller_rr: RTL and testbench



---
 rtl/mem_controller_rr.sv | 213 +++++++++++++++++++++
 tb/tb_mem_controller_rr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller_rr.sv
// Round-robin arbiter of consumer read/write requests onto NUM_CHANNELS memory channels, with per-channel timeout.
// Consumer ready lands one edge after memory ready (>=2 edges from request); requests with no idle channel wait with valid held.
module mem_controller_rr #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 16,
   parameter int NUM_CONSUMERS  = 4,
   parameter int NUM_CHANNELS   = 2,
   parameter int WRITE_ENABLE   = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
   output logic [$clog2(NUM_CHANNELS+1)-1:0]  channels_busy,
   output logic [NUM_CHANNELS-1:0]            timeout_err
);

   localparam int CW = $clog2(NUM_CONSUMERS);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int BW = $clog2(NUM_CHANNELS + 1);
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CW:0]   NC_L    = (CW+1)'(NUM_CONSUMERS);
   localparam logic [CW:0]   NC_M1   = (CW+1)'(NUM_CONSUMERS - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_t;

   state_t                                    r_state   [NUM_CHANNELS];
   logic [CW-1:0]                             r_cons    [NUM_CHANNELS];
   logic [TW-1:0]                             r_cnt     [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]                   r_mrv;
   logic [NUM_CHANNELS-1:0]                   r_mwv;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    r_mraddr;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    r_mwaddr;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    r_mwdat;
   logic [NUM_CHANNELS-1:0]                   r_terr;
   logic [NUM_CONSUMERS-1:0]                  r_claimed;
   logic [NUM_CONSUMERS-1:0]                  r_crr;
   logic [NUM_CONSUMERS-1:0]                  r_cwr;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   r_crd;
   logic [CW-1:0]                             r_rr_ptr;

   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   w_raddr;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   w_waddr;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   w_wdat;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    w_mrdat;
   logic [NUM_CONSUMERS-1:0]                  w_wv_en;
   logic [NUM_CONSUMERS-1:0]                  w_pend;
   logic [NUM_CONSUMERS-1:0]                  w_taken;
   logic [NUM_CHANNELS-1:0]                   w_gnt;
   logic [CW-1:0]                             w_gnt_idx [NUM_CHANNELS];
   logic [CW-1:0]                             w_next_ptr;
   logic [CW:0]                               w_sum;
   logic                                      w_found;

   assign w_raddr = consumer_read_address;
   assign w_waddr = consumer_write_address;
   assign w_wdat  = consumer_write_data;
   assign w_mrdat = mem_read_data;
   assign w_wv_en = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
   assign w_pend  = (consumer_read_valid | w_wv_en) & ~r_claimed;

   // Each idle channel, in ascending order, takes the next untaken pending consumer from rr_ptr onward.
   always_comb begin
      w_taken    = '0;
      w_next_ptr = r_rr_ptr;
      w_sum      = '0;
      w_found    = 1'b0;
      w_gnt      = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         w_gnt_idx[i] = '0;
         w_found      = 1'b0;
         for (int k = 0; k < NUM_CONSUMERS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (CW+1)'(k);
            if (w_sum >= NC_L) w_sum = w_sum - NC_L;
            if (r_state[i] == IDLE && !w_found && w_pend[w_sum[CW-1:0]] && !w_taken[w_sum[CW-1:0]]) begin
               w_found                 = 1'b1;
               w_gnt[i]                = 1'b1;
               w_gnt_idx[i]            = w_sum[CW-1:0];
               w_taken[w_sum[CW-1:0]]  = 1'b1;
               w_next_ptr              = (w_sum == NC_M1) ? '0 : w_sum[CW-1:0] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr  <= '0;
         r_claimed <= '0;
         r_crr     <= '0;
         r_cwr     <= '0;
         r_crd     <= '0;
         r_mrv     <= '0;
         r_mwv     <= '0;
         r_mraddr  <= '0;
         r_mwaddr  <= '0;
         r_mwdat   <= '0;
         r_terr    <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_state[i] <= IDLE;
            r_cons[i]  <= '0;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_rr_ptr <= w_next_ptr;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (r_state[i])
               IDLE: begin
                  if (w_gnt[i]) begin
                     r_cons[i]               <= w_gnt_idx[i];
                     r_claimed[w_gnt_idx[i]] <= 1'b1;
                     r_cnt[i]                <= '0;
                     if (consumer_read_valid[w_gnt_idx[i]]) begin
                        r_state[i]  <= READ_WAITING;
                        r_mrv[i]    <= 1'b1;
                        r_mraddr[i] <= w_raddr[w_gnt_idx[i]];
                     end else begin
                        r_state[i]  <= WRITE_WAITING;
                        r_mwv[i]    <= 1'b1;
                        r_mwaddr[i] <= w_waddr[w_gnt_idx[i]];
                        r_mwdat[i]  <= w_wdat[w_gnt_idx[i]];
                     end
                  end
               end
               READ_WAITING: begin
                  if (mem_read_ready[i]) begin
                     r_mrv[i]           <= 1'b0;
                     r_crr[r_cons[i]]   <= 1'b1;
                     r_crd[r_cons[i]]   <= w_mrdat[i];
                     r_state[i]         <= READ_RELAYING;
                  end else if (TIMEOUT_CYCLES != 0 && r_cnt[i] == TO_LAST) begin
                     r_mrv[i]           <= 1'b0;
                     r_crr[r_cons[i]]   <= 1'b1;
                     r_crd[r_cons[i]]   <= '0;
                     r_terr[i]          <= 1'b1;
                     r_state[i]         <= READ_RELAYING;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + TW'(1);
                  end
               end
               WRITE_WAITING: begin
                  if (mem_write_ready[i]) begin
                     r_mwv[i]           <= 1'b0;
                     r_cwr[r_cons[i]]   <= 1'b1;
                     r_state[i]         <= WRITE_RELAYING;
                  end else if (TIMEOUT_CYCLES != 0 && r_cnt[i] == TO_LAST) begin
                     r_mwv[i]           <= 1'b0;
                     r_cwr[r_cons[i]]   <= 1'b1;
                     r_terr[i]          <= 1'b1;
                     r_state[i]         <= WRITE_RELAYING;
                  end else begin
                     r_cnt[i] <= r_cnt[i] + TW'(1);
                  end
               end
               READ_RELAYING: begin
                  if (!consumer_read_valid[r_cons[i]]) begin
                     r_crr[r_cons[i]]     <= 1'b0;
                     r_claimed[r_cons[i]] <= 1'b0;
                     r_state[i]           <= IDLE;
                  end
               end
               WRITE_RELAYING: begin
                  if (!consumer_write_valid[r_cons[i]]) begin
                     r_cwr[r_cons[i]]     <= 1'b0;
                     r_claimed[r_cons[i]] <= 1'b0;
                     r_state[i]           <= IDLE;
                  end
               end
               default: r_state[i] <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      channels_busy = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (r_state[i] != IDLE) channels_busy = channels_busy + BW'(1);
      end
   end

   assign consumer_read_ready  = r_crr;
   assign consumer_read_data   = r_crd;
   assign consumer_write_ready = (WRITE_ENABLE != 0) ? r_cwr : '0;
   assign mem_read_valid       = r_mrv;
   assign mem_read_address     = r_mraddr;
   assign mem_write_valid      = (WRITE_ENABLE != 0) ? r_mwv : '0;
   assign mem_write_address    = (WRITE_ENABLE != 0) ? r_mwaddr : '0;
   assign mem_write_data       = (WRITE_ENABLE != 0) ? r_mwdat : '0;
   assign timeout_err          = r_terr;

endmodule

// File: tb/tb_mem_controller_rr.sv
// Randomized consumers and memories around mem_controller_rr, checked each cycle against a transaction-level model.
module tb_mem_controller_rr;

   localparam int AB   = 8;
   localparam int DB   = 16;
   localparam int NC   = 4;
   localparam int NCH  = 2;
   localparam int TO   = 6;
   localparam int NCYC = 4000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NC-1:0]          rv, wv;
   logic [NC-1:0][AB-1:0]  raddr, waddr;
   logic [NC-1:0][DB-1:0]  wdat;
   logic [NCH-1:0]         mrr, mwr;
   logic [NCH-1:0][DB-1:0] mrd;

   logic [NC-1:0]          consumer_read_ready, consumer_write_ready;
   logic [NC*DB-1:0]       consumer_read_data;
   logic [NCH-1:0]         mem_read_valid, mem_write_valid, timeout_err;
   logic [NCH*AB-1:0]      mem_read_address, mem_write_address;
   logic [NCH*DB-1:0]      mem_write_data;
   logic [1:0]             channels_busy;

   logic [NC-1:0]          ro_crr, ro_cwr;
   logic [NC*DB-1:0]       ro_crd;
   logic [0:0]             ro_mrv, ro_mwv, ro_busy, ro_terr;
   logic [AB-1:0]          ro_mra, ro_mwa;
   logic [DB-1:0]          ro_mwd;

   mem_controller_rr #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH),
                       .WRITE_ENABLE(1), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(rv), .consumer_read_address(raddr),
      .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
      .consumer_write_valid(wv), .consumer_write_address(waddr), .consumer_write_data(wdat),
      .consumer_write_ready(consumer_write_ready),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mrr), .mem_read_data(mrd),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mwr),
      .channels_busy(channels_busy), .timeout_err(timeout_err)
   );

   // Read-only variant sharing the consumer stimulus: must never show any write activity.
   mem_controller_rr #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                       .WRITE_ENABLE(0), .TIMEOUT_CYCLES(0)) dut_ro (
      .clk(clk), .reset(reset),
      .consumer_read_valid(rv), .consumer_read_address(raddr),
      .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
      .consumer_write_valid(wv), .consumer_write_address(waddr), .consumer_write_data(wdat),
      .consumer_write_ready(ro_cwr),
      .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
      .mem_read_ready(1'b1), .mem_read_data(16'h5A5A),
      .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
      .mem_write_data(ro_mwd), .mem_write_ready(1'b1),
      .channels_busy(ro_busy), .timeout_err(ro_terr)
   );

   // Reference model: channel ownership and expected outputs
   int  owner   [NCH];
   bit  ch_wr   [NCH];
   bit  ch_rel  [NCH];
   int  ch_wait [NCH];
   bit  stall   [NCH];
   bit  claimed [NC];
   int  rr;
   int  cs      [NC];

   logic [NCH-1:0]         e_mrv, e_mwv, e_terr;
   logic [NCH-1:0][AB-1:0] e_mraddr, e_mwaddr;
   logic [NCH-1:0][DB-1:0] e_mwdat;
   logic [NC-1:0]          e_crr, e_cwr;
   logic [NC-1:0][DB-1:0]  e_crd;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      rr = 0;
      for (int i = 0; i < NCH; i++) begin
         owner[i] = -1; ch_wr[i] = 0; ch_rel[i] = 0; ch_wait[i] = 0; stall[i] = 0;
      end
      for (int j = 0; j < NC; j++) claimed[j] = 0;
      e_mrv = '0; e_mwv = '0; e_terr = '0; e_mraddr = '0; e_mwaddr = '0; e_mwdat = '0;
      e_crr = '0; e_cwr = '0; e_crd = '0;
   endtask

   task automatic model_step();
      int q[$];
      bit idle0 [NCH];
      int j, last;
      bit any, rdy, tmo;
      for (int k = 0; k < NC; k++) begin
         j = (rr + k) % NC;
         if ((rv[j] || wv[j]) && !claimed[j]) q.push_back(j);
      end
      for (int i = 0; i < NCH; i++) idle0[i] = (owner[i] < 0);
      for (int i = 0; i < NCH; i++) begin
         if (!idle0[i]) begin
            j = owner[i];
            if (!ch_rel[i]) begin
               rdy = ch_wr[i] ? mwr[i] : mrr[i];
               tmo = !rdy && (ch_wait[i] + 1 == TO);
               if (rdy || tmo) begin
                  e_mrv[i] = 0; e_mwv[i] = 0; ch_rel[i] = 1;
                  if (ch_wr[i]) e_cwr[j] = 1;
                  else begin
                     e_crr[j] = 1;
                     e_crd[j] = rdy ? mrd[i] : '0;
                  end
                  if (tmo) e_terr[i] = 1;
               end else begin
                  ch_wait[i]++;
               end
            end else if (ch_wr[i] ? !wv[j] : !rv[j]) begin
               if (ch_wr[i]) e_cwr[j] = 0; else e_crr[j] = 0;
               claimed[j] = 0;
               owner[i]   = -1;
            end
         end
      end
      any = 0; last = 0;
      for (int i = 0; i < NCH; i++) begin
         if (idle0[i] && q.size() > 0) begin
            j = q.pop_front();
            owner[i] = j; ch_wr[i] = !rv[j]; ch_rel[i] = 0; ch_wait[i] = 0;
            claimed[j] = 1;
            stall[i] = ($urandom_range(0, 5) == 0);
            if (!ch_wr[i]) begin
               e_mrv[i] = 1; e_mraddr[i] = raddr[j];
            end else begin
               e_mwv[i] = 1; e_mwaddr[i] = waddr[j]; e_mwdat[i] = wdat[j];
            end
            any = 1; last = j;
         end
      end
      if (any) rr = (last + 1) % NC;
   endtask

   task automatic check_outputs();
      int nbusy;
      nbusy = 0;
      for (int i = 0; i < NCH; i++) if (owner[i] >= 0) nbusy++;
      check("mem_read_valid", 64'(mem_read_valid), 64'(e_mrv));
      check("mem_write_valid", 64'(mem_write_valid), 64'(e_mwv));
      for (int i = 0; i < NCH; i++) begin
         if (e_mrv[i]) check("mem_read_address", 64'(mem_read_address[i*AB +: AB]), 64'(e_mraddr[i]));
         if (e_mwv[i]) begin
            check("mem_write_address", 64'(mem_write_address[i*AB +: AB]), 64'(e_mwaddr[i]));
            check("mem_write_data", 64'(mem_write_data[i*DB +: DB]), 64'(e_mwdat[i]));
         end
      end
      check("consumer_read_ready", 64'(consumer_read_ready), 64'(e_crr));
      check("consumer_read_data", 64'(consumer_read_data), 64'(e_crd));
      check("consumer_write_ready", 64'(consumer_write_ready), 64'(e_cwr));
      check("channels_busy", 64'(channels_busy), 64'(nbusy));
      check("timeout_err", 64'(timeout_err), 64'(e_terr));
      check("ro_write_silent", 64'({ro_mwv, ro_mwa, ro_mwd, ro_cwr}), 64'd0);
   endtask

   task automatic drive(input int cyc);
      int k;
      bit resp;
      reset = (cyc == 1500 || cyc == 3100);
      for (int j = 0; j < NC; j++) begin
         if (reset) begin
            cs[j] = 0; rv[j] = 0; wv[j] = 0;
         end else if (cs[j] == 0) begin
            if ($urandom_range(0, 2) == 0) begin
               k = $urandom_range(0, 4);
               rv[j] = (k < 2) || (k == 4);
               wv[j] = (k >= 2);
               raddr[j] = {6'($urandom), 2'(j)};
               waddr[j] = {6'($urandom), 2'(j)};
               wdat[j]  = 16'($urandom);
               cs[j] = 1;
            end
         end else if ((e_crr[j] || e_cwr[j]) && $urandom_range(0, 1) == 0) begin
            rv[j] = 0; wv[j] = 0; cs[j] = 0;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         resp   = !stall[i] && ($urandom_range(0, 2) == 0);
         mrr[i] = e_mrv[i] ? resp : 1'($urandom_range(0, 1));
         mwr[i] = e_mwv[i] ? resp : 1'($urandom_range(0, 1));
         mrd[i] = 16'($urandom);
      end
   endtask

   initial begin
      reset = 1'b1;
      rv = '0; wv = '0; raddr = '0; waddr = '0; wdat = '0;
      mrr = '0; mwr = '0; mrd = '0;
      for (int j = 0; j < NC; j++) cs[j] = 0;
      model_reset();
      repeat (3) @(posedge clk);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         check_outputs();
         drive(cyc);
         @(posedge clk);
         if (reset) model_reset();
         else       model_step();
      end
      @(negedge clk);
      check_outputs();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
